// File: rtl/esm_issue_core.sv
// rtl/esm_issue_core.sv - out-of-order issue window with age-ordered RAW/WAW/WAR tracking
// Optional ESM_PERF_CNT_EN adds occupancy and issue_count outputs.
module esm_issue_core #(
  parameter int IW      = 32,
  parameter int BS      = 16,
  parameter int REGNUM  = 16,
  parameter int ISSUE_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IW-1:0]                 in_instr,
  input  logic                          in_reg_write,
  input  logic                          in_alu_src,
  input  logic                          issue_stall,
  output logic [ISSUE_W-1:0]            issue_valid,
  output logic [ISSUE_W*$clog2(BS)-1:0] issue_index,
  output logic [ISSUE_W*IW-1:0]         issue_instr,
  input  logic                          cmp_valid,
  input  logic [$clog2(BS)-1:0]         cmp_index
`ifdef ESM_PERF_CNT_EN
  ,
  output logic [$clog2(BS):0]           occupancy,
  output logic [31:0]                   issue_count
`endif
);

  localparam int RW  = $clog2(REGNUM);
  localparam int XW  = $clog2(BS);
  localparam int RKW = XW + 1;

  logic [BS-1:0] valid;
  logic [BS-1:0] issued;
  logic [BS-1:0] reg_write;
  logic [BS-1:0] alu_src;
  logic [IW-1:0] instr [BS];
  // age[i][j] = 1 when entry j is older than entry i
  logic [BS-1:0] age [BS];

  logic [RW-1:0]  rd  [BS];
  logic [RW-1:0]  rs1 [BS];
  logic [RW-1:0]  rs2 [BS];
  logic [BS-1:0]  blocked;
  logic [BS-1:0]  cand;
  logic [RKW-1:0] rank [BS];
  logic [BS-1:0]  pick;
  logic [XW-1:0]  alloc_idx;
  logic           alloc;
  logic           cmp_ok;

  always_comb begin
    for (int i = 0; i < BS; i++) begin
      rd[i]  = instr[i][7+:RW];
      rs1[i] = instr[i][15+:RW];
      rs2[i] = instr[i][20+:RW];
    end
  end

  always_comb begin
    for (int i = 0; i < BS; i++) begin
      blocked[i] = 1'b0;
      for (int j = 0; j < BS; j++) begin
        if (valid[j] && age[i][j] &&
            ((reg_write[j] && (rd[j] == rs1[i] || (!alu_src[i] && rd[j] == rs2[i]))) ||
             (reg_write[j] && reg_write[i] && rd[j] == rd[i]) ||
             (reg_write[i] && (rs1[j] == rd[i] || (!alu_src[j] && rs2[j] == rd[i])))))
          blocked[i] = 1'b1;
      end
    end
  end

  assign cand = valid & ~issued & ~blocked;

  // Valid entries form a total age order, so a candidate's rank among older
  // candidates uniquely names the slot it would occupy.
  always_comb begin
    for (int i = 0; i < BS; i++) begin
      rank[i] = '0;
      for (int j = 0; j < BS; j++) begin
        if (cand[j] && age[i][j])
          rank[i] = rank[i] + RKW'(1);
      end
    end
  end

  always_comb begin
    issue_valid = '0;
    issue_index = '0;
    issue_instr = '0;
    pick        = '0;
    if (!issue_stall) begin
      for (int s = 0; s < ISSUE_W; s++) begin
        for (int i = 0; i < BS; i++) begin
          if (cand[i] && rank[i] == RKW'(s)) begin
            issue_valid[s]            = 1'b1;
            issue_index[s*XW +: XW]   = XW'(i);
            issue_instr[s*IW +: IW]   = instr[i];
            pick[i]                   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (!valid[i])
        alloc_idx = XW'(i);
    end
  end

  assign in_ready = ~&valid;
  assign alloc    = in_valid & in_ready;
  assign cmp_ok   = cmp_valid & valid[cmp_index] & issued[cmp_index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= '0;
      issued    <= '0;
      reg_write <= '0;
      alu_src   <= '0;
      for (int i = 0; i < BS; i++) begin
        instr[i] <= '0;
        age[i]   <= '0;
      end
    end else begin
      issued <= issued | pick;
      if (cmp_ok)
        valid[cmp_index] <= 1'b0;
      if (alloc) begin
        valid[alloc_idx]     <= 1'b1;
        issued[alloc_idx]    <= 1'b0;
        instr[alloc_idx]     <= in_instr;
        reg_write[alloc_idx] <= in_reg_write;
        alu_src[alloc_idx]   <= in_alu_src;
        age[alloc_idx]       <= valid;
        for (int x = 0; x < BS; x++)
          age[x][alloc_idx] <= 1'b0;
      end
    end
  end

`ifdef ESM_PERF_CNT_EN
  logic [2:0] n_issued;

  always_comb begin
    n_issued = '0;
    for (int s = 0; s < ISSUE_W; s++)
      n_issued = n_issued + {2'b00, issue_valid[s]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy   <= '0;
      issue_count <= '0;
    end else begin
      occupancy <= occupancy + RKW'(alloc) - RKW'(cmp_ok);
      if (issue_count > (32'hFFFF_FFFF - {29'd0, n_issued}))
        issue_count <= 32'hFFFF_FFFF;
      else
        issue_count <= issue_count + {29'd0, n_issued};
    end
  end
`endif

endmodule

// File: tb/tb_esm_issue_core.sv
// tb/tb_esm_issue_core.sv - randomized self-checking bench for esm_issue_core
// Reference model keeps valid entries in an age-ordered queue.
module tb_esm_issue_core;

  localparam int IW      = 32;
  localparam int BS      = 16;
  localparam int REGNUM  = 16;
  localparam int ISSUE_W = 2;
  localparam int XW      = 4;
  localparam int RW      = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [IW-1:0]         in_instr = '0;
  logic                  in_reg_write = 1'b0;
  logic                  in_alu_src = 1'b0;
  logic                  issue_stall = 1'b0;
  logic [ISSUE_W-1:0]    issue_valid;
  logic [ISSUE_W*XW-1:0] issue_index;
  logic [ISSUE_W*IW-1:0] issue_instr;
  logic                  cmp_valid = 1'b0;
  logic [XW-1:0]         cmp_index = '0;
`ifdef ESM_PERF_CNT_EN
  logic [XW:0]           occupancy;
  logic [31:0]           issue_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  esm_issue_core #(.IW(IW), .BS(BS), .REGNUM(REGNUM), .ISSUE_W(ISSUE_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_reg_write(in_reg_write), .in_alu_src(in_alu_src),
    .issue_stall(issue_stall), .issue_valid(issue_valid),
    .issue_index(issue_index), .issue_instr(issue_instr),
    .cmp_valid(cmp_valid), .cmp_index(cmp_index)
`ifdef ESM_PERF_CNT_EN
    , .occupancy(occupancy), .issue_count(issue_count)
`endif
  );

  bit          m_valid  [BS];
  bit          m_issued [BS];
  bit          m_rw     [BS];
  bit          m_as     [BS];
  logic [31:0] m_instr  [BS];
  int          order [$];
  int          m_iss_total;

  logic                  exp_ready;
  logic [ISSUE_W-1:0]    exp_valid;
  logic [ISSUE_W*XW-1:0] exp_index;
  logic [ISSUE_W*IW-1:0] exp_instr;
  bit                    exp_pick [BS];

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w = $urandom;
    w[7+:RW]  = rd[RW-1:0];
    w[15+:RW] = rs1[RW-1:0];
    w[20+:RW] = rs2[RW-1:0];
    return w;
  endfunction

  // true when older entry j must finish before entry i may issue
  function automatic bit depends(input int i, input int j);
    logic [RW-1:0] di, s1i, s2i, dj, s1j, s2j;
    di = m_instr[i][7+:RW];  s1i = m_instr[i][15+:RW]; s2i = m_instr[i][20+:RW];
    dj = m_instr[j][7+:RW];  s1j = m_instr[j][15+:RW]; s2j = m_instr[j][20+:RW];
    return (m_rw[j] && (dj == s1i || (!m_as[i] && dj == s2i))) ||
           (m_rw[j] && m_rw[i] && dj == di) ||
           (m_rw[i] && (s1j == di || (!m_as[j] && s2j == di)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BS; i++) begin
      m_valid[i] = 0; m_issued[i] = 0; m_rw[i] = 0; m_as[i] = 0; m_instr[i] = '0;
    end
    order.delete();
    m_iss_total = 0;
  endtask

  task automatic model_expect();
    int n;
    bit blk;
    exp_ready = (order.size() < BS);
    exp_valid = '0; exp_index = '0; exp_instr = '0;
    n = 0;
    for (int i = 0; i < BS; i++) exp_pick[i] = 0;
    if (!issue_stall) begin
      for (int p = 0; p < order.size(); p++) begin
        if (n < ISSUE_W && !m_issued[order[p]]) begin
          blk = 0;
          for (int q = 0; q < p; q++)
            if (depends(order[p], order[q])) blk = 1;
          if (!blk) begin
            exp_valid[n]           = 1'b1;
            exp_index[n*XW +: XW]  = XW'(order[p]);
            exp_instr[n*IW +: IW]  = m_instr[order[p]];
            exp_pick[order[p]]     = 1;
            n++;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    int k;
    int ci;
    bit cmp_ok;
    ci = int'(cmp_index);
    cmp_ok = cmp_valid && m_valid[ci] && m_issued[ci];
    k = -1;
    for (int i = BS - 1; i >= 0; i--) if (!m_valid[i]) k = i;
    for (int i = 0; i < BS; i++) begin
      if (exp_pick[i]) begin m_issued[i] = 1; m_iss_total++; end
    end
    if (cmp_ok) begin
      m_valid[ci] = 0;
      for (int p = 0; p < order.size(); p++)
        if (order[p] == ci) begin order.delete(p); break; end
    end
    if (in_valid && exp_ready) begin
      m_valid[k] = 1; m_issued[k] = 0; m_instr[k] = in_instr;
      m_rw[k] = in_reg_write; m_as[k] = in_alu_src;
      order.push_back(k);
    end
  endtask

  task automatic drive(input bit iv, input logic [31:0] ins, input bit rw, input bit as_,
                       input bit st, input bit cv, input int ci);
    in_valid = iv; in_instr = ins; in_reg_write = rw; in_alu_src = as_;
    issue_stall = st; cmp_valid = cv; cmp_index = ci[XW-1:0];
    #2;
    model_expect();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    drive(0, '0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b1 || issue_valid !== '0 || issue_index !== '0 || issue_instr !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b valid=%b idx=%h instr=%h want 1/0/0/0", in_ready, issue_valid, issue_index, issue_instr);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      drive(0, '0, 0, 0, 0, 0, 0);
      checks++;
      if (in_ready !== 1'b1 || issue_valid !== '0) begin
        failures++;
        $display("FAIL idle_outputs ready=%b valid=%b want 1/00", in_ready, issue_valid);
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, mk(i + 1, 8, 9), 0, 0, 1, 0, 0);
      tick();
    end
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b11 || issue_index !== 8'h10) begin
      failures++;
      $display("FAIL pre_reset_issue valid=%b idx=%h want 11/10", issue_valid, issue_index);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || issue_valid !== '0 || issue_index !== '0 || issue_instr !== '0) begin
      failures++;
      $display("FAIL async_reset ready=%b valid=%b idx=%h want 1/00/00", in_ready, issue_valid, issue_index);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== '0) begin
      failures++;
      $display("FAIL post_reset_empty valid=%b want 00", issue_valid);
    end
    tick();
  endtask

  task automatic test_raw();
    logic [31:0] a, b;
    do_reset();
    a = mk(3, 1, 2);
    b = mk(4, 3, 1);
    drive(1, a, 1, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b00) begin failures++; $display("FAIL raw_empty valid=%b want 00", issue_valid); end
    tick();
    drive(1, b, 1, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b01 || issue_index[3:0] !== 4'd0 || issue_instr[31:0] !== a) begin
      failures++; $display("FAIL raw_a_issue valid=%b idx=%h want 01/slot0=0", issue_valid, issue_index);
    end
    tick();
    drive(0, '0, 0, 0, 0, 1, 0);
    checks++;
    if (issue_valid !== 2'b00) begin failures++; $display("FAIL raw_b_blocked valid=%b want 00", issue_valid); end
    tick();
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b01 || issue_index[3:0] !== 4'd1 || issue_instr[31:0] !== b) begin
      failures++; $display("FAIL raw_b_issue valid=%b idx=%h want 01/slot0=1", issue_valid, issue_index);
    end
    tick();
  endtask

  task automatic test_independent();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, mk((i < 2) ? i + 1 : i + 3, 8 + 2 * i, 9 + 2 * i), 1, 0, 1, 0, 0);
      tick();
    end
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b11 || issue_index !== 8'h10) begin
      failures++; $display("FAIL indep_first valid=%b idx=%h want 11/10", issue_valid, issue_index);
    end
    tick();
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b11 || issue_index !== 8'h32) begin
      failures++; $display("FAIL indep_second valid=%b idx=%h want 11/32", issue_valid, issue_index);
    end
    tick();
  endtask

  task automatic test_war();
    do_reset();
    drive(1, mk(1, 2, 7), 1, 0, 1, 0, 0); tick();
    drive(1, mk(7, 3, 4), 1, 0, 1, 0, 0); tick();
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b01 || issue_index[3:0] !== 4'd0) begin
      failures++; $display("FAIL war_a_only valid=%b idx=%h want 01/slot0=0", issue_valid, issue_index);
    end
    tick();
    drive(0, '0, 0, 0, 0, 1, 0);
    checks++;
    if (issue_valid !== 2'b00) begin failures++; $display("FAIL war_b_blocked valid=%b want 00", issue_valid); end
    tick();
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b01 || issue_index[3:0] !== 4'd1) begin
      failures++; $display("FAIL war_b_after valid=%b idx=%h want 01/slot0=1", issue_valid, issue_index);
    end
    tick();
    do_reset();
    drive(1, mk(1, 2, 7), 1, 1, 1, 0, 0); tick();
    drive(1, mk(7, 3, 4), 1, 0, 1, 0, 0); tick();
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b11 || issue_index !== 8'h10) begin
      failures++; $display("FAIL war_imm_both valid=%b idx=%h want 11/10", issue_valid, issue_index);
    end
    tick();
  endtask

  task automatic test_full_reuse();
    logic [31:0] x, y;
    do_reset();
    for (int i = 0; i < BS; i++) begin
      drive(1, mk(i, i, i), 0, 0, 0, 0, 0);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready i=%0d ready=%b want 1", i, in_ready); end
      tick();
    end
    x = mk(1, 2, 3);
    y = mk(4, 5, 6);
    drive(1, x, 0, 0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_not_ready ready=%b want 0", in_ready); end
    tick();
    drive(1, x, 0, 0, 1, 1, 9);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL freed_same_cycle ready=%b want 0", in_ready); end
    tick();
    drive(1, x, 0, 0, 1, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL freed_next_cycle ready=%b want 1", in_ready); end
    tick();
    drive(1, y, 0, 0, 1, 1, 2);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL refull ready=%b want 0", in_ready); end
    tick();
    drive(1, y, 0, 0, 1, 0, 0);
    tick();
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b11 || issue_index !== 8'h29 || issue_instr !== {y, x}) begin
      failures++; $display("FAIL reuse_order valid=%b idx=%h want 11/29", issue_valid, issue_index);
    end
    tick();
  endtask

  task automatic test_stall_ignore();
    do_reset();
    drive(1, mk(1, 8, 9), 0, 0, 1, 0, 0); tick();
    drive(1, mk(2, 10, 11), 0, 0, 1, 0, 0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, '0, 0, 0, 1, 1, 0);
      checks++;
      if (issue_valid !== 2'b00 || in_ready !== 1'b1) begin
        failures++; $display("FAIL stall_hold c=%0d valid=%b ready=%b want 00/1", c, issue_valid, in_ready);
      end
      tick();
    end
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (issue_valid !== 2'b11 || issue_index !== 8'h10) begin
      failures++; $display("FAIL stall_release valid=%b idx=%h want 11/10", issue_valid, issue_index);
    end
    tick();
  endtask

  task automatic test_random();
    int done [$];
    int ci;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      done.delete();
      for (int i = 0; i < BS; i++) if (m_valid[i] && m_issued[i]) done.push_back(i);
      ci = int'($urandom_range(BS - 1));
      if (done.size() > 0 && $urandom_range(4) != 0) ci = done[$urandom_range(done.size() - 1)];
      drive(bit'($urandom_range(9) < 7), mk(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(7))),
            bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(6) == 0),
            bit'($urandom_range(1)), ci);
      checks++;
      if ({in_ready, issue_valid, issue_index, issue_instr} !== {exp_ready, exp_valid, exp_index, exp_instr}) begin
        failures++;
        $display("FAIL random c=%0d ready=%b valid=%b idx=%h want ready=%b valid=%b idx=%h", c,
                 in_ready, issue_valid, issue_index, exp_ready, exp_valid, exp_index);
      end
`ifdef ESM_PERF_CNT_EN
      checks++;
      if (occupancy !== (XW + 1)'(order.size()) || issue_count !== 32'(m_iss_total)) begin
        failures++;
        $display("FAIL random_perf c=%0d occ=%0d cnt=%0d want %0d/%0d", c, occupancy, issue_count, order.size(), m_iss_total);
      end
`endif
      tick();
    end
  endtask

`ifdef ESM_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, mk(i, 8, 9), 0, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin drive(0, '0, 0, 0, 0, 0, 0); tick(); end
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (occupancy !== 5'd6 || issue_count !== 32'd6) begin
      failures++; $display("FAIL perf_six occ=%0d cnt=%0d want 6/6", occupancy, issue_count);
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, '0, 0, 0, 0, 1, i);
      tick();
    end
    drive(0, '0, 0, 0, 0, 0, 0);
    checks++;
    if (occupancy !== 5'd0 || issue_count !== 32'd6) begin
      failures++; $display("FAIL perf_drained occ=%0d cnt=%0d want 0/6", occupancy, issue_count);
    end
    tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_raw();
    test_independent();
    test_war();
    test_full_reuse();
    test_stall_ignore();
`ifdef ESM_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/esm_issue_core.md
Name: esm_issue_core

Overview:
- Parametrised successor to the ESM dependency-analysis core.
- Holds up to BS decoded instructions in an out-of-order window.
- Tracks register dependencies (RAW/WAW/WAR) between entries by age, and issues up to ISSUE_W mutually independent instructions per cycle, oldest first.
- Entries are freed by completion reports from execution units.

Parameters:
IW, 32, instruction word width
BS, 16, window depth (entries), power of two, >= 2
REGNUM, 16, architectural register count, power of two; RW = $clog2(REGNUM)
ISSUE_W, 2, maximum issues per cycle, 1..4

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  new instruction offered
in_ready  output  1  window has a free entry
in_instr  input  IW  instruction word; rd=[7+:RW], rs1=[15+:RW], rs2=[20+:RW]
in_reg_write  input  1  instruction writes rd
in_alu_src  input  1  1 = immediate operand, rs2 not read
issue_stall  input  1  1 = no issue this cycle
issue_valid  output  ISSUE_W  per-slot issue strobe
issue_index  output  ISSUE_W*$clog2(BS)  window index per slot, slot 0 in LSBs
issue_instr  output  ISSUE_W*IW  instruction per slot
cmp_valid  input  1  completion report
cmp_index  input  $clog2(BS)  entry completing

Behaviour:
- Reset (rst=0, asynchronous): all entries invalid, age matrix cleared.
  - Outputs at reset: in_ready=1, issue_valid=0, issue_index=0, issue_instr=0.
- Entry state: valid, issued, instr, reg_write, alu_src, plus a BSxBS age matrix. age[i][j]=1 means j is older than i.
- Allocation (in_valid & in_ready at a clock edge):
  - Write the lowest-index free entry k; set valid[k]=1, issued[k]=0.
  - Set age[k][j]=valid[j] for all j.
  - Clear age[x][k] for all x.
- in_ready = any valid==0. It is combinational from registered state only: an entry freed this cycle is not reusable until the next cycle.
- Dependency: entry i is blocked if any valid j with age[i][j]=1 satisfies at least one of:
  - RAW: reg_write_j and (rd_j==rs1_i or (!alu_src_i and rd_j==rs2_i)).
  - WAW: reg_write_j and reg_write_i and rd_j==rd_i.
  - WAR: reg_write_i and (rs1_j==rd_i or (!alu_src_j and rs2_j==rd_i)).
- Issued-but-not-completed entries still block. No register is special.
- Issue selection (combinational, from registered state):
  - Candidates: valid & !issued & !blocked.
  - Pick up to ISSUE_W candidates in age order; slot 0 gets the oldest.
  - Unused slots: issue_valid=0, index/instr=0.
  - If issue_stall=1, all slots invalid.
  - Issued entries get issued=1 at the clock edge.
- Latency: an entry allocated at edge t is first issuable in cycle t (after the edge); it never issues in the cycle it is being written.
- Completion (cmp_valid at edge):
  - If valid[cmp_index] & issued[cmp_index]: clear valid. Dependents unblock from the next cycle.
  - Otherwise the report is ignored (no state change).
- Simultaneous events:
  - Allocation, issue and completion in one cycle are independent; all use pre-edge state.
  - A completion of entry k in the same cycle as allocation never targets k, because k is free.
- Full window: in_ready=0; in_valid is held by the producer.
- Empty window: issue_valid=0.

Optional Feature:
ESM_PERF_CNT_EN
- Defined: adds output occupancy (width $clog2(BS)+1), the number of valid entries (registered, reset 0).
- Also adds output issue_count (32 bits), the total instructions issued. It saturates at 2^32-1 and resets to 0.
- Not defined: neither port exists and there is no counter logic.

Test Plan:
- Reset then idle -> in_ready=1, issue_valid=0. Assert rst=0 mid-stream with 5 entries valid -> all cleared; in_ready=1 immediately.
- Write A(rd=3), B(rs1=3, rd=4), with ISSUE_W=2 -> only A issues (slot 0). Complete A -> B issues the next cycle.
- Write four independent instrs (rd=1,2,5,6, disjoint sources) -> cycle 1 issues the two oldest (slots 0 and 1), cycle 2 issues the other two.
- WAR: A(rs2=7, alu_src=0), B(rd=7) -> B blocked until A completes. Repeat with A alu_src=1 -> B issues alongside A.
- Fill 16 entries -> in_ready=0. Complete index 9 -> in_ready=1 next cycle; the next write lands in entry 9 and is youngest in issue order.
- Completion for an unissued entry, or issue_stall=1 for 3 cycles -> no state change, no issue.
- With ESM_PERF_CNT_EN: 6 allocations and 6 issues -> occupancy=6, issue_count=6. After 6 completions -> occupancy=0.
